// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one lower-part-OR approximate adder between NREQ requesters.
// One grant per cycle; the sum is returned through a registered response slot tagged with ID and level.
module approx_add_arbiter #(
   parameter int W     = 8,
   parameter int NREQ  = 4,
   parameter int LVL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   input  logic [NREQ*LVL_W-1:0]   req_lvl,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [W:0]              resp_y,
   output logic [$clog2(NREQ)-1:0] resp_id,
   output logic [LVL_W-1:0]        resp_lvl
);

   localparam int IDW = $clog2(NREQ);

   function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
      if (int'(lvl) > W) return LVL_W'(W);
      return lvl;
   endfunction

   // Bits below p are OR'd; the top approximated bit pair seeds the exact upper carry chain.
   function automatic logic [W:0] approx_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [LVL_W-1:0] p);
      logic [W:0] y;
      logic       c;
      y = '0;
      c = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i < int'(p)) begin
            y[i] = a[i] | b[i];
            if (i == int'(p) - 1) c = a[i] & b[i];
         end else begin
            y[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | ((a[i] | b[i]) & c);
         end
      end
      y[W] = c;
      return y;
   endfunction

   logic [IDW-1:0]   r_ptr;
   logic             r_valid;
   logic [W:0]       r_y;
   logic [IDW-1:0]   r_id;
   logic [LVL_W-1:0] r_lvl;

   logic             w_slot_free;
   logic             w_found;
   logic             w_accept;
   logic [IDW-1:0]   w_gnt;
   logic [IDW-1:0]   w_ptr_nxt;
   logic [W-1:0]     w_a;
   logic [W-1:0]     w_b;
   logic [LVL_W-1:0] w_lvl_eff;
   logic [W:0]       w_sum;

   always_comb begin
      int j;
      j       = 0;
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!w_found && req_valid[IDW'(j)]) begin
            w_found = 1'b1;
            w_gnt   = IDW'(j);
         end
      end
   end

   assign w_slot_free = !r_valid || resp_ready;
   assign w_accept    = rst_n && w_slot_free && w_found;
   assign req_ready   = w_accept ? (NREQ'(1) << w_gnt) : '0;
   assign w_ptr_nxt   = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;

   assign w_a       = req_a[w_gnt*W +: W];
   assign w_b       = req_b[w_gnt*W +: W];
   assign w_lvl_eff = clamp_lvl(req_lvl[w_gnt*LVL_W +: LVL_W]);
   assign w_sum     = approx_add(w_a, w_b, w_lvl_eff);

   // Response slot: an accept overwrites, a drain without accept empties it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_y     <= '0;
         r_id    <= '0;
         r_lvl   <= '0;
         r_ptr   <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_y     <= w_sum;
         r_id    <= w_gnt;
         r_lvl   <= w_lvl_eff;
         r_ptr   <= w_ptr_nxt;
      end else if (resp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign resp_valid = r_valid;
   assign resp_y     = r_y;
   assign resp_id    = r_id;
   assign resp_lvl   = r_lvl;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Bench for approx_add_arbiter: directed cases with literal expectations plus randomized
// traffic compared every cycle against an arithmetic model of the arbiter and adder.
module tb_approx_add_arbiter;

   localparam int W     = 8;
   localparam int NREQ  = 4;
   localparam int LVL_W = 4;
   localparam int IDW   = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*W-1:0]     req_a;
   logic [NREQ*W-1:0]     req_b;
   logic [NREQ*LVL_W-1:0] req_lvl;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [W:0]            resp_y;
   logic [IDW-1:0]        resp_id;
   logic [LVL_W-1:0]      resp_lvl;

   int n_pass  = 0;
   int n_total = 0;

   int m_ptr   = 0;
   int m_valid = 0;
   int m_y     = 0;
   int m_id    = 0;
   int m_lvl   = 0;
   int g_last  = -1;

   approx_add_arbiter #(.W(W), .NREQ(NREQ), .LVL_W(LVL_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_lvl    (req_lvl),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .resp_id    (resp_id),
      .resp_lvl   (resp_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff_lvl(int l);
      return (l > W) ? W : l;
   endfunction

   // Low p bits are A|B; the upper field is an ordinary integer add plus the seed carry.
   function automatic int model_add(int a, int b, int l);
      int p, mask, c;
      p    = eff_lvl(l);
      mask = (1 << p) - 1;
      c    = (p > 0) ? (((a >> (p - 1)) & (b >> (p - 1))) & 1) : 0;
      return ((a | b) & mask) | (((a >> p) + (b >> p) + c) << p);
   endfunction

   function automatic int a_of(int i);
      return int'(req_a[i*W +: W]);
   endfunction
   function automatic int b_of(int i);
      return int'(req_b[i*W +: W]);
   endfunction
   function automatic int lvl_of(int i);
      return int'(req_lvl[i*LVL_W +: LVL_W]);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic set_req(input int i, input int a, input int b, input int l);
      req_a[i*W +: W]         = W'(a);
      req_b[i*W +: W]         = W'(b);
      req_lvl[i*LVL_W +: LVL_W] = LVL_W'(l);
      req_valid[i]            = 1'b1;
   endtask

   // One clock: check the combinational grant, advance the model, check registered outputs.
   task automatic cycle();
      int g;
      #1;
      g = -1;
      if (rst_n && (m_valid == 0 || resp_ready)) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
      check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
      if (!rst_n) begin
         m_valid = 0; m_y = 0; m_id = 0; m_lvl = 0; m_ptr = 0;
      end else if (g >= 0) begin
         m_valid = 1;
         m_y     = model_add(a_of(g), b_of(g), lvl_of(g));
         m_id    = g;
         m_lvl   = eff_lvl(lvl_of(g));
         m_ptr   = (g + 1) % NREQ;
      end else if (resp_ready) begin
         m_valid = 0;
      end
      g_last = g;
      @(posedge clk);
      @(negedge clk);
      check("resp_valid", int'(resp_valid), m_valid);
      check("resp_y", int'(resp_y), m_y);
      check("resp_id", int'(resp_id), m_id);
      check("resp_lvl", int'(resp_lvl), m_lvl);
   endtask

   initial begin
      int y0, id0, others, got3;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_lvl    = '0;
      resp_ready = 1'b1;
      cycle();
      cycle();
      check("rst_valid", int'(resp_valid), 0);
      check("rst_y", int'(resp_y), 0);
      check("rst_id", int'(resp_id), 0);
      rst_n = 1'b1;

      set_req(0, 'h0F, 'h01, 0);
      cycle();
      check("exact_y", int'(resp_y), 'h010);
      check("exact_id", int'(resp_id), 0);
      check("exact_lvl", int'(resp_lvl), 0);
      req_valid = '0;

      set_req(0, 'h0F, 'h01, 2);
      cycle();
      check("approx2_y", int'(resp_y), 'h00F);
      req_valid = '0;
      set_req(1, 'hFF, 'h01, 1);
      cycle();
      check("approx1_y", int'(resp_y), 'h101);
      check("approx1_id", int'(resp_id), 1);
      req_valid = '0;
      set_req(2, 'hA5, 'h96, 15);
      cycle();
      check("clamp_lvl", int'(resp_lvl), 8);
      check("clamp_y", int'(resp_y), 'h1B7);
      req_valid = '0;

      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 16 * i + 3, 7 * i + 1, i);
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("rr_id", int'(resp_id), k % NREQ);
         check("rr_valid", int'(resp_valid), 1);
      end

      resp_ready = 1'b0;
      y0  = int'(resp_y);
      id0 = int'(resp_id);
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("bp_ready", int'(req_ready), 0);
         check("bp_y", int'(resp_y), y0);
         check("bp_id", int'(resp_id), id0);
      end
      resp_ready = 1'b1;
      cycle();
      check("bp_resume_id", int'(resp_id), (id0 + 1) % NREQ);

      rst_n     = 1'b0;
      req_valid = '0;
      cycle();
      rst_n = 1'b1;
      set_req(3, 'h33, 'h44, 3);
      set_req(0, 'h10, 'h20, 0);
      set_req(1, 'h11, 'h21, 1);
      others = 0;
      got3   = 0;
      for (int k = 0; k < 12 && got3 == 0; k++) begin
         req_valid[0] = ((k % 2) == 0) || !req_ready[0];
         req_valid[1] = ((k % 2) == 1) || !req_ready[1];
         req_valid[0] = 1'b1;
         req_valid[1] = 1'b1;
         cycle();
         if (g_last == 3) got3 = 1;
         else if (g_last >= 0) others++;
      end
      check("fair_within", (got3 == 1 && others < NREQ) ? 1 : 0, 1);
      check("fair_others", others, 2);

      req_valid = '0;
      set_req(0, 'h01, 'h02, 0);
      cycle();
      check("pre_rst_valid", int'(resp_valid), 1);
      set_req(2, 'h05, 'h06, 0);
      resp_ready = 1'b0;
      rst_n      = 1'b0;
      cycle();
      check("midrst_valid", int'(resp_valid), 0);
      rst_n      = 1'b1;
      resp_ready = 1'b1;
      cycle();
      check("midrst_first_id", int'(resp_id), 0);

      req_valid = '0;
      g_last    = -1;
      for (int c = 0; c < 1500; c++) begin
         if (g_last >= 0) req_valid[g_last] = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 15)));
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
